count_seq_ctrl: RTL and testbench
=================================

COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001: Parameter DIV, default 25000000: clock cycles per automatic advance in RUN; legal range is 2 or more.
REQ-002: Parameter DB_CYCLES, default 500000: consecutive stable samples needed to accept a button level; legal range is 1 or more.
REQ-003: Parameter LAST, default 5: highest count value in the sequence; legal range is 1 to 7.
REQ-004: clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005: rst  input  1  reset; synchronous, active-high.
REQ-006: btn_run  input  1  raw run/pause push-button; asynchronous, bouncing, active-high.
REQ-007: btn_step  input  1  raw single-step push-button; asynchronous, bouncing, active-high.
REQ-008: dir  input  1  direction: 0 counts up, 1 counts down; sampled only on an advance cycle.
REQ-009: count  output  3  sequence index feeding the downstream 7-segment ROM; registered.
REQ-010: adv  output  1  one-cycle pulse, asserted in the same cycle count shows its new value.
REQ-011: running  output  1  high while the FSM is in RUN; registered.

Function
REQ-012: Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013: Debounce: a new synchronized level SHALL be accepted after DB_CYCLES consecutive equal samples; any mismatch SHALL restart the stability counter.
REQ-014: A press pulse SHALL be one cycle wide, generated on the 0->1 transition of the debounced level; a release SHALL generate nothing.
REQ-015: FSM states are IDLE, RUN and PAUSE; the state entered from reset is IDLE.
REQ-016: IDLE + run press -> RUN.
REQ-017: RUN + run press -> PAUSE.
REQ-018: PAUSE + run press -> RUN.
REQ-019: IDLE + step press -> one advance, then PAUSE.
REQ-020: PAUSE + step press -> one advance, remain in PAUSE.
REQ-021: RUN + step press -> ignored.
REQ-022: Run press and step press in the same cycle: the run press SHALL take effect and the step press SHALL be discarded.
REQ-023: Prescaler: a counter from 0 to DIV-1 SHALL run only in RUN and be held at 0 in every other state; when it wraps from DIV-1 it SHALL produce a tick.
REQ-024: In RUN, a tick SHALL cause one advance.
REQ-025: A tick and a run press in the same cycle: the state SHALL go to PAUSE with no advance.
REQ-026: Advance, dir=0: count+1; LAST wraps to 0.
REQ-027: Advance, dir=1: count-1; 0 wraps to LAST.
REQ-028: If an advance finds count greater than LAST, count SHALL be forced to 0.
REQ-029: Latency: count and adv SHALL update on the clock edge after the cycle holding the tick or press pulse, so adv is high for exactly one cycle per advance.
REQ-030: After a run press into RUN, the first advance SHALL occur exactly DIV cycles after the state change.
REQ-031: count SHALL hold its value in PAUSE and never change except on an advance or a reset.

Reset
REQ-032: While rst=1 at a clock edge, the next state SHALL be: count=0, adv=0, running=0, FSM=IDLE, prescaler=0, debounced levels=0, stability counters=0, synchronizers=0.
REQ-033: Reset SHALL take priority over every other event, including a tick or press in the same cycle.
REQ-034: A reset mid-RUN or mid-debounce SHALL abandon the operation with no adv pulse.
REQ-035: A button held high through reset release SHALL produce one press only after DB_CYCLES stable samples.

Verification (DIV=4, DB_CYCLES=3, LAST=5)
REQ-036: Reset, then btn_run held 10 cycles -> exactly one run press; running=1; adv every 4 cycles; count 1,2,3,4,5,0,1.
REQ-037: btn_run toggling every cycle for 20 cycles, then held low -> no press, state unchanged.
REQ-038: In PAUSE at count=0 with dir=1, one clean btn_step press -> count=5 and one adv pulse; running=0.
REQ-039: In RUN, run press aligned to a tick cycle -> PAUSE, count unchanged, no adv.
REQ-040: Both buttons pressed together from IDLE -> RUN, no step advance; rst asserted mid-RUN at count=3 -> count=0, running=0 next cycle.

Source files
------------

// File: rtl/count_seq_ctrl.sv
// Run/pause/single-step sequencer: debounced buttons steer an IDLE/RUN/PAUSE FSM that walks count over 0..LAST.
// Press pulse lands 2 sync + DB_CYCLES cycles after a clean edge; count/adv update one cycle after the tick or press.
module count_seq_ctrl #(
  parameter int DIV       = 25000000,
  parameter int DB_CYCLES = 500000,
  parameter int LAST      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic       dir,
  output logic [2:0] count,
  output logic       adv,
  output logic       running
);

  localparam int PW = $clog2(DIV);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [DW-1:0] DB_MAX  = DW'(DB_CYCLES - 1);
  localparam logic [2:0]    LAST_V  = 3'(LAST);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    sync1, sync2, db_lvl, press;   // bit 0 = run button, bit 1 = step button
  logic [DW-1:0] db_cnt [2];
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          adv_nxt;
  logic [2:0]    count_nxt;

  // db_cnt counts consecutive samples disagreeing with the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      db_lvl <= '0;
      press  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {btn_step, btn_run};
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          db_cnt[i] <= '0;
          db_lvl[i] <= sync2[i];
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign tick = (state == RUN) && (pre_cnt == PRE_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A run press always wins: it swallows a same-cycle step press or tick.
  always_comb begin
    state_nxt = state;
    adv_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (press[0]) begin
          state_nxt = RUN;
        end else if (press[1]) begin
          state_nxt = PAUSE;
          adv_nxt   = 1'b1;
        end
      end
      RUN: begin
        if (press[0]) state_nxt = PAUSE;
        else          adv_nxt   = tick;
      end
      PAUSE: begin
        if (press[0])      state_nxt = RUN;
        else if (press[1]) adv_nxt   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if (count > LAST_V)  count_nxt = '0;
    else if (dir)        count_nxt = (count == 3'd0) ? LAST_V : count - 3'd1;
    else                 count_nxt = (count == LAST_V) ? 3'd0 : count + 3'd1;
  end

  // Prescaler restarts at 0 on every entry to RUN so the first advance is DIV cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      count   <= '0;
      adv     <= 1'b0;
      running <= 1'b0;
    end else begin
      adv     <= adv_nxt;
      running <= (state_nxt == RUN);
      if (adv_nxt) count <= count_nxt;
      if ((state == RUN) && (state_nxt == RUN)) pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      else                                      pre_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: directed table, hand-built corner sequences and a random run against a reference model.
module tb_count_seq_ctrl;

  localparam int DIV  = 4;
  localparam int DB   = 3;
  localparam int LAST = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_run = 1'b0;
  logic       btn_step = 1'b0;
  logic       dir = 1'b0;
  logic [2:0] count;
  logic       adv;
  logic       running;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int adv_total = 0;
  int adv_cnt[$];
  int adv_cyc[$];

  count_seq_ctrl #(.DIV(DIV), .DB_CYCLES(DB), .LAST(LAST)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step), .dir(dir),
    .count(count), .adv(adv), .running(running)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step_clk();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step_clk();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (adv === 1'b1) begin
      adv_total++;
      adv_cnt.push_back(int'(count));
      adv_cyc.push_back(cyc);
    end
  end

  // Reference model: debounce as "last DB synchronized samples all agree", prescaler as cycles-in-RUN modulo DIV.
  function automatic int next_count(input int c, input logic d);
    if (c > LAST) return 0;
    return d ? (c + LAST) % (LAST + 1) : (c + 1) % (LAST + 1);
  endfunction

  int          m_count, m_mode, m_age;   // m_mode: 0 idle, 1 run, 2 pause
  bit          m_adv;
  bit          m_valid = 1'b0;
  logic [15:0] m_hist [2];
  bit          m_lvl [2];
  bit          m_pr [2];

  always @(posedge clk) begin : model
    bit go;
    int nmode;
    logic [DB-1:0] win;
    logic raw;
    if (rst) begin
      m_count = 0; m_adv = 1'b0; m_mode = 0; m_age = 0; m_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_hist[i] = '0; m_lvl[i] = 1'b0; m_pr[i] = 1'b0;
      end
    end else begin
      go = 1'b0;
      nmode = m_mode;
      if (m_pr[0])          nmode = (m_mode == 1) ? 2 : 1;
      else if (m_mode == 1) go = ((m_age % DIV) == DIV - 1);
      else if (m_pr[1]) begin
        go = 1'b1;
        nmode = 2;
      end
      m_adv = go;
      if (go) m_count = next_count(m_count, dir);
      m_age  = (m_mode == 1 && nmode == 1) ? m_age + 1 : 0;
      m_mode = nmode;
      for (int i = 0; i < 2; i++) begin
        win = m_hist[i][DB:1];
        m_pr[i] = 1'b0;
        if (!m_lvl[i] && (&win)) begin
          m_lvl[i] = 1'b1;
          m_pr[i]  = 1'b1;
        end else if (m_lvl[i] && (win == '0)) begin
          m_lvl[i] = 1'b0;
        end
        raw = (i == 0) ? btn_run : btn_step;
        m_hist[i] = {m_hist[i][14:0], raw};
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_count", int'(count), m_count);
      chk("model_adv", int'(adv), int'(m_adv));
      chk("model_running", int'(running), int'(m_mode == 1));
    end
  end

  typedef struct {
    int   run_hi;
    int   step_hi;
    int   toggles;
    logic d;
    int   exp_count;
    int   exp_run;
    int   exp_advs;
  } vec_t;

  vec_t vt [10];

  initial begin
    int base, run_cyc, hit, hold, hr, hs;
    int seq_exp [7];
    seq_exp = '{1, 2, 3, 4, 5, 0, 1};
    vt = '{
      '{0, 0, 20, 1'b0, 0, 0, 0},   // bouncing run button in IDLE
      '{0, 2, 0,  1'b0, 0, 0, 0},   // step pulse one sample short of DB
      '{0, 3, 0,  1'b0, 1, 0, 1},   // step held exactly DB samples: IDLE -> PAUSE
      '{0, 6, 0,  1'b1, 0, 0, 1},   // step down
      '{0, 4, 0,  1'b1, 5, 0, 1},   // step down wraps 0 -> LAST
      '{0, 5, 0,  1'b0, 0, 0, 1},   // step up wraps LAST -> 0
      '{0, 0, 20, 1'b0, 0, 0, 0},   // bouncing run button in PAUSE
      '{3, 0, 0,  1'b0, 2, 1, 2},   // PAUSE -> RUN, two ticks inside the window
      '{3, 0, 0,  1'b0, 3, 0, 1},   // RUN -> PAUSE after one more tick
      '{0, 3, 0,  1'b1, 2, 0, 1}    // step down while paused
    };

    rst = 1'b1;
    repeat (3) step_clk();
    chk("reset_count", int'(count), 0);
    chk("reset_adv", int'(adv), 0);
    chk("reset_running", int'(running), 0);
    rst = 1'b0;

    foreach (vt[r]) begin
      base = adv_total;
      dir = vt[r].d;
      if (vt[r].toggles > 0) begin
        for (int t = 0; t < vt[r].toggles; t++) begin
          btn_run = ~btn_run;
          step_clk();
        end
        btn_run = 1'b0;
      end else begin
        hold = (vt[r].run_hi > vt[r].step_hi) ? vt[r].run_hi : vt[r].step_hi;
        btn_run  = (vt[r].run_hi > 0);
        btn_step = (vt[r].step_hi > 0);
        for (int t = 1; t <= hold; t++) begin
          step_clk();
          if (t == vt[r].run_hi)  btn_run = 1'b0;
          if (t == vt[r].step_hi) btn_step = 1'b0;
        end
      end
      repeat (12) step_clk();
      chk($sformatf("vec%0d_count", r), int'(count), vt[r].exp_count);
      chk($sformatf("vec%0d_running", r), int'(running), vt[r].exp_run);
      chk($sformatf("vec%0d_advs", r), adv_total - base, vt[r].exp_advs);
    end

    // Run held 10 cycles from reset: one press, advance every DIV cycles.
    btn_run = 1'b0; btn_step = 1'b0; dir = 1'b0;
    do_reset();
    adv_cnt.delete();
    adv_cyc.delete();
    run_cyc = -1;
    btn_run = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      step_clk();
      if (k == 10) btn_run = 1'b0;
      if (running && run_cyc < 0) run_cyc = cyc;
    end
    chk("run_hold_adv_n", adv_cnt.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < adv_cnt.size()) begin
        chk($sformatf("run_seq%0d", i), adv_cnt[i], seq_exp[i]);
        chk($sformatf("run_gap%0d", i), adv_cyc[i] - ((i == 0) ? run_cyc : adv_cyc[i-1]), DIV);
      end
    end
    chk("run_hold_running", int'(running), 1);

    // Run press whose pulse coincides with a tick: pause wins, no advance.
    hit = 0;
    for (int k = 0; k < 12 && hit == 0; k++) begin
      step_clk();
      if (adv) hit = 1;
    end
    chk("tick_wait", hit, 1);
    chk("tick_pre_count", int'(count), 2);
    step_clk();
    step_clk();
    btn_run = 1'b1;
    base = adv_total;
    for (int k = 1; k <= 12; k++) begin
      step_clk();
      if (k == 4) btn_run = 1'b0;
    end
    chk("tick_press_advs", adv_total - base, 1);
    chk("tick_press_count", int'(count), 3);
    chk("tick_press_running", int'(running), 0);

    // Both buttons together from IDLE, then reset in the middle of RUN.
    btn_run = 1'b0;
    do_reset();
    base = adv_total;
    btn_run = 1'b1;
    btn_step = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step_clk();
      if (k == 5) begin
        btn_run = 1'b0;
        btn_step = 1'b0;
      end
    end
    chk("both_running", int'(running), 1);
    chk("both_count", int'(count), 0);
    chk("both_advs", adv_total - base, 0);
    hit = 0;
    for (int k = 0; k < 40 && hit == 0; k++) begin
      step_clk();
      if (count == 3'd3) hit = 1;
    end
    chk("mid_run_reach3", hit, 1);
    rst = 1'b1;
    step_clk();
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_running", int'(running), 0);
    chk("mid_rst_adv", int'(adv), 0);
    rst = 1'b0;
    base = adv_total;
    repeat (10) step_clk();
    chk("post_rst_advs", adv_total - base, 0);
    chk("post_rst_running", int'(running), 0);

    // Button held through reset release presses only after DB stable samples.
    rst = 1'b1;
    btn_run = 1'b1;
    step_clk();
    step_clk();
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step_clk();
      if (k == 5) chk("held_rst_early", int'(running), 0);
    end
    chk("held_rst_press", int'(running), 1);
    btn_run = 1'b0;

    // Random bouncing buttons, direction and occasional resets against the model.
    do_reset();
    hr = 0;
    hs = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hr <= 0) begin
        btn_run = 1'($urandom_range(0, 1));
        hr = $urandom_range(1, 12);
      end
      if (hs <= 0) begin
        btn_step = 1'($urandom_range(0, 1));
        hs = $urandom_range(1, 12);
      end
      hr--;
      hs--;
      dir = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 399) == 0);
      step_clk();
    end
    rst = 1'b0;
    btn_run = 1'b0;
    btn_step = 1'b0;
    repeat (5) step_clk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
